// File: rtl/wb_regfile.sv
// MEM/WB pipeline register, writeback-source mux and 32-entry integer register file.
// Build option: define WB_BYPASS_EN for the write-first bypass from the MEM/WB register onto the read ports.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            mem_we,
  input  logic [AW-1:0]   mem_wR,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_c,
  input  logic [XLEN-1:0] mem_dram_rd,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [XLEN-1:0] mem_sext,
  input  logic            stall,
  input  logic            flush,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  output logic [XLEN-1:0] rD1,
  output logic [XLEN-1:0] rD2,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [AW-1:0]   wb_wR,
  output logic [XLEN-1:0] wb_wD
);

  logic            r_wb_valid;
  logic            r_wb_we;
  logic [AW-1:0]   r_wb_wR;
  logic [XLEN-1:0] r_wb_wD;
  logic [XLEN-1:0] r_rf [NREG];
  logic [XLEN-1:0] w_wb_mux;
  logic            w_commit;

  always_comb begin
    w_wb_mux = mem_alu_c;
    case (mem_wb_sel)
      2'b00: w_wb_mux = mem_alu_c;
      2'b01: w_wb_mux = mem_dram_rd;
      2'b10: w_wb_mux = mem_pc4;
      2'b11: w_wb_mux = mem_sext;
      default: w_wb_mux = mem_alu_c;
    endcase
  end

  // flush outranks stall; on flush only the valid/enable bits are cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_wR    <= '0;
      r_wb_wD    <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
    end else if (!stall) begin
      r_wb_valid <= mem_valid;
      r_wb_we    <= mem_we & mem_valid;
      r_wb_wR    <= mem_wR;
      r_wb_wD    <= w_wb_mux;
    end
  end

  assign w_commit = r_wb_valid & r_wb_we & (r_wb_wR != '0);

  // commit ignores stall: re-writing the held value is harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_commit) begin
      r_rf[r_wb_wR] <= r_wb_wD;
    end
  end

  always_comb begin
    rD1 = '0;
    if (rR1 != '0) begin
`ifdef WB_BYPASS_EN
      if (w_commit && (r_wb_wR == rR1)) rD1 = r_wb_wD;
      else                              rD1 = r_rf[rR1];
`else
      rD1 = r_rf[rR1];
`endif
    end
  end

  always_comb begin
    rD2 = '0;
    if (rR2 != '0) begin
`ifdef WB_BYPASS_EN
      if (w_commit && (r_wb_wR == rR2)) rD2 = r_wb_wD;
      else                              rD2 = r_rf[rR2];
`else
      rD2 = r_rf[rR2];
`endif
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_we    = r_wb_we;
  assign wb_wR    = r_wb_wR;
  assign wb_wD    = r_wb_wD;

endmodule
